// File: rtl/vga_frame_switch.sv
// Frame-synchronous VGA source selector: changes the selected source only on a VSYNC
// assertion of the current source, and can optionally hold RGB black for a few frames afterwards.
module vga_frame_switch #(
    parameter int                 NUM_SRC      = 3,
    parameter int                 COLOR_W      = 1,
    parameter logic               SYNC_ACTIVE  = 1'b0,
    parameter int                 BLANK_FRAMES = 0,
    parameter logic [NUM_SRC-1:0] DEFAULT_SEL  = NUM_SRC'(1)
) (
    input  logic                         CLK_40M,
    input  logic                         RSTn,
    input  logic [NUM_SRC-1:0]           src_vsync,
    input  logic [NUM_SRC-1:0]           src_hsync,
    input  logic [NUM_SRC*3*COLOR_W-1:0] src_rgb,
    input  logic [NUM_SRC-1:0]           sel_onehot,
    output logic                         VSYNC_Sig_out,
    output logic                         HSYNC_Sig_out,
    output logic [COLOR_W-1:0]           VGA_red_out,
    output logic [COLOR_W-1:0]           VGA_green_out,
    output logic [COLOR_W-1:0]           VGA_blue_out,
    output logic [NUM_SRC-1:0]           active_sel,
    output logic                         switch_busy,
    output logic                         switch_done
);

    localparam int PIX_W = 3 * COLOR_W;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        BLANK   = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [NUM_SRC-1:0] active_sel_reg, active_sel_next;
    logic [NUM_SRC-1:0] pending_reg, pending_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               vs_prev_reg, vs_prev_next;
    logic               done_reg, done_next;
    logic               busy_reg;
    logic               vsync_reg, hsync_reg;
    logic [PIX_W-1:0]   rgb_reg;

    logic [NUM_SRC-1:0] vs_terms, hs_terms;
    logic [PIX_W-1:0]   rgb_terms [NUM_SRC];
    logic               mux_vs, mux_hs;
    logic [PIX_W-1:0]   mux_rgb;
    logic               new_vs;
    logic               frame_edge;
    logic               sel_valid;

    // AND-OR mux: each source is gated by its select bit, then everything is OR-reduced.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_mux
            assign vs_terms[gi]  = src_vsync[gi] & active_sel_reg[gi];
            assign hs_terms[gi]  = src_hsync[gi] & active_sel_reg[gi];
            assign rgb_terms[gi] = src_rgb[gi*PIX_W +: PIX_W] & {PIX_W{active_sel_reg[gi]}};
        end
    endgenerate

    assign mux_vs = |vs_terms;
    assign mux_hs = |hs_terms;

    always_comb begin
        mux_rgb = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            mux_rgb = mux_rgb | rgb_terms[i];
        end
    end

    assign new_vs     = |(src_vsync & pending_reg);
    assign frame_edge = (mux_vs == SYNC_ACTIVE) && (vs_prev_reg != SYNC_ACTIVE);
    assign sel_valid  = (sel_onehot != '0) &&
                        ((sel_onehot & (sel_onehot - NUM_SRC'(1))) == '0);

    always_comb begin
        state_next      = state_reg;
        active_sel_next = active_sel_reg;
        pending_next    = pending_reg;
        cnt_next        = cnt_reg;
        vs_prev_next    = mux_vs;
        done_next       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (sel_valid && (sel_onehot != active_sel_reg)) begin
                    pending_next = sel_onehot;
                    state_next   = WAIT_VS;
                end
            end

            WAIT_VS: begin
                if (sel_onehot == active_sel_reg) begin
                    state_next = IDLE;
                end else if (frame_edge) begin
                    active_sel_next = pending_reg;
                    // Seed edge history from the incoming source so its level cannot fake an edge.
                    vs_prev_next    = new_vs;
                    if (BLANK_FRAMES == 0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        cnt_next   = CNT_W'(BLANK_FRAMES);
                        state_next = BLANK;
                    end
                end else if (sel_valid && (sel_onehot != pending_reg)) begin
                    pending_next = sel_onehot;
                end
            end

            BLANK: begin
                if (frame_edge) begin
                    if (cnt_reg <= CNT_W'(1)) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_40M) begin
        if (!RSTn) begin
            state_reg      <= IDLE;
            active_sel_reg <= DEFAULT_SEL;
            pending_reg    <= '0;
            cnt_reg        <= '0;
            vs_prev_reg    <= ~SYNC_ACTIVE;
            done_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            vsync_reg      <= ~SYNC_ACTIVE;
            hsync_reg      <= ~SYNC_ACTIVE;
            rgb_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            active_sel_reg <= active_sel_next;
            pending_reg    <= pending_next;
            cnt_reg        <= cnt_next;
            vs_prev_reg    <= vs_prev_next;
            done_reg       <= done_next;
            busy_reg       <= (state_next != IDLE);
            vsync_reg      <= mux_vs;
            hsync_reg      <= mux_hs;
            // Syncs keep flowing during blanking so the monitor stays locked.
            rgb_reg        <= (state_reg == BLANK) ? '0 : mux_rgb;
        end
    end

    assign VSYNC_Sig_out = vsync_reg;
    assign HSYNC_Sig_out = hsync_reg;
    assign VGA_red_out   = rgb_reg[2*COLOR_W +: COLOR_W];
    assign VGA_green_out = rgb_reg[COLOR_W +: COLOR_W];
    assign VGA_blue_out  = rgb_reg[0 +: COLOR_W];
    assign active_sel    = active_sel_reg;
    assign switch_busy   = busy_reg;
    assign switch_done   = done_reg;

endmodule

// File: tb/tb_vga_frame_switch.sv
// Bench for vga_frame_switch: directed vector table on two instances (no blanking / 2-frame
// blanking), a frame-paced blanking sequence, then random traffic against an index-based model.
module tb_vga_frame_switch;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic [2:0] src_vsync, src_hsync, sel;
    logic [8:0] src_rgb;

    logic       vs0, hs0, r0, g0, b0, busy0, done0;
    logic [2:0] act0;
    logic       vs2, hs2, r2, g2, b2, busy2, done2;
    logic [2:0] act2;

    vga_frame_switch #(
        .NUM_SRC(3), .COLOR_W(1), .SYNC_ACTIVE(1'b0), .BLANK_FRAMES(0), .DEFAULT_SEL(3'b001)
    ) dut0 (
        .CLK_40M(clk), .RSTn(rstn), .src_vsync(src_vsync), .src_hsync(src_hsync),
        .src_rgb(src_rgb), .sel_onehot(sel), .VSYNC_Sig_out(vs0), .HSYNC_Sig_out(hs0),
        .VGA_red_out(r0), .VGA_green_out(g0), .VGA_blue_out(b0), .active_sel(act0),
        .switch_busy(busy0), .switch_done(done0)
    );

    vga_frame_switch #(
        .NUM_SRC(3), .COLOR_W(1), .SYNC_ACTIVE(1'b0), .BLANK_FRAMES(2), .DEFAULT_SEL(3'b001)
    ) dut2 (
        .CLK_40M(clk), .RSTn(rstn), .src_vsync(src_vsync), .src_hsync(src_hsync),
        .src_rgb(src_rgb), .sel_onehot(sel), .VSYNC_Sig_out(vs2), .HSYNC_Sig_out(hs2),
        .VGA_red_out(r2), .VGA_green_out(g2), .VGA_blue_out(b2), .active_sel(act2),
        .switch_busy(busy2), .switch_done(done2)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    // Directed vectors: inputs applied before a clock edge, expected outputs just after it.
    typedef struct packed {
        logic       rstn;
        logic [2:0] vs;
        logic [2:0] sel;
        logic [2:0] act;
        logic       bz0;
        logic       dn0;
        logic [2:0] rgb0;
        logic       bz2;
        logic       dn2;
        logic [2:0] rgb2;
        logic       ovs;
    } vec_t;

    // Reference model: tracks the selected source by index and the switch phase by plain counters.
    typedef struct {
        int         act;
        int         pend;
        int         phase;   // 0 steady, 1 waiting for frame, 2 blanking
        int         left;
        bit         prev;
        bit         ovs;
        bit         ohs;
        bit [2:0]   orgb;
        bit         done;
    } model_t;

    function automatic int req_index(input bit [2:0] s);
        int n = 0;
        int idx = -1;
        for (int i = 0; i < 3; i++) if (s[i]) begin n++; idx = i; end
        return (n == 1) ? idx : -1;
    endfunction

    function automatic model_t model_step(input model_t m, input int nb, input bit rst_n,
                                          input bit [2:0] vs, input bit [2:0] hs,
                                          input bit [8:0] rgb, input bit [2:0] s);
        model_t n = m;
        bit     mv;
        bit     fe;
        int     req;
        if (!rst_n) begin
            n.act = 0; n.pend = 0; n.phase = 0; n.left = 0; n.prev = 1'b1;
            n.ovs = 1'b1; n.ohs = 1'b1; n.orgb = 3'b000; n.done = 1'b0;
            return n;
        end
        mv     = vs[m.act];
        fe     = (mv == 1'b0) && (m.prev == 1'b1);
        req    = req_index(s);
        n.ovs  = mv;
        n.ohs  = hs[m.act];
        n.orgb = (m.phase == 2) ? 3'b000 : rgb[m.act*3 +: 3];
        n.done = 1'b0;
        n.prev = mv;
        if (m.phase == 0) begin
            if (req >= 0 && req != m.act) begin n.pend = req; n.phase = 1; end
        end else if (m.phase == 1) begin
            if (req == m.act) n.phase = 0;
            else if (fe) begin
                n.act  = m.pend;
                n.prev = vs[m.pend];
                if (nb == 0) begin n.phase = 0; n.done = 1'b1; end
                else begin n.phase = 2; n.left = nb; end
            end else if (req >= 0 && req != m.pend) n.pend = req;
        end else begin
            if (fe) begin
                n.left = m.left - 1;
                if (n.left == 0) begin n.phase = 0; n.done = 1'b1; end
            end
        end
        return n;
    endfunction

    function automatic logic [9:0] model_out(input model_t m);
        return {3'(1 << m.act), (m.phase != 0), m.done, m.ovs, m.ohs, m.orgb};
    endfunction

    vec_t   tbl [23];
    model_t m0, m2;

    initial begin
        //            rstn  vs      sel     act     bz0   dn0   rgb0    bz2   dn2   rgb2    ovs
        tbl[0]  = '{1'b0, 3'b111, 3'b001, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1};
        tbl[1]  = '{1'b1, 3'b111, 3'b001, 3'b001, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 3'b101, 1'b1};
        tbl[2]  = '{1'b1, 3'b111, 3'b011, 3'b001, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 3'b101, 1'b1};
        tbl[3]  = '{1'b1, 3'b111, 3'b000, 3'b001, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 3'b101, 1'b1};
        tbl[4]  = '{1'b1, 3'b111, 3'b010, 3'b001, 1'b1, 1'b0, 3'b101, 1'b1, 1'b0, 3'b101, 1'b1};
        tbl[5]  = '{1'b1, 3'b111, 3'b010, 3'b001, 1'b1, 1'b0, 3'b101, 1'b1, 1'b0, 3'b101, 1'b1};
        tbl[6]  = '{1'b1, 3'b110, 3'b010, 3'b010, 1'b0, 1'b1, 3'b101, 1'b1, 1'b0, 3'b101, 1'b0};
        tbl[7]  = '{1'b1, 3'b110, 3'b010, 3'b010, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 3'b000, 1'b1};
        tbl[8]  = '{1'b1, 3'b100, 3'b010, 3'b010, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 3'b000, 1'b0};
        tbl[9]  = '{1'b1, 3'b100, 3'b010, 3'b010, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 3'b000, 1'b0};
        tbl[10] = '{1'b1, 3'b111, 3'b010, 3'b010, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 3'b000, 1'b1};
        tbl[11] = '{1'b1, 3'b101, 3'b010, 3'b010, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 3'b000, 1'b0};
        tbl[12] = '{1'b1, 3'b101, 3'b010, 3'b010, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 3'b010, 1'b0};
        tbl[13] = '{1'b1, 3'b111, 3'b001, 3'b010, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 3'b010, 1'b1};
        tbl[14] = '{1'b1, 3'b111, 3'b010, 3'b010, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 3'b010, 1'b1};
        tbl[15] = '{1'b1, 3'b111, 3'b100, 3'b010, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 3'b010, 1'b1};
        tbl[16] = '{1'b1, 3'b101, 3'b010, 3'b010, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 3'b010, 1'b0};
        tbl[17] = '{1'b1, 3'b111, 3'b100, 3'b010, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 3'b010, 1'b1};
        tbl[18] = '{1'b1, 3'b111, 3'b001, 3'b010, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 3'b010, 1'b1};
        tbl[19] = '{1'b1, 3'b101, 3'b001, 3'b001, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 3'b010, 1'b0};
        tbl[20] = '{1'b1, 3'b101, 3'b001, 3'b001, 1'b0, 1'b0, 3'b101, 1'b1, 1'b0, 3'b000, 1'b1};
        tbl[21] = '{1'b0, 3'b111, 3'b001, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1};
        tbl[22] = '{1'b1, 3'b111, 3'b001, 3'b001, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 3'b101, 1'b1};

        rstn      = 1'b0;
        src_vsync = 3'b111;
        src_hsync = 3'b111;
        src_rgb   = 9'b111_010_101;
        sel       = 3'b001;

        for (int i = 0; i < 23; i++) begin
            rstn      = tbl[i].rstn;
            src_vsync = tbl[i].vs;
            sel       = tbl[i].sel;
            @(posedge clk); #1;
            $display("vec %0d: rstn=%b vs=%b sel=%b -> act=%b/%b busy=%b/%b done=%b/%b rgb=%b/%b",
                     i, rstn, src_vsync, sel, act0, act2, busy0, busy2, done0, done2,
                     {r0, g0, b0}, {r2, g2, b2});
            check($sformatf("vec%0d_act0", i), 32'(act0), 32'(tbl[i].act));
            check($sformatf("vec%0d_act2", i), 32'(act2), 32'(tbl[i].act));
            check($sformatf("vec%0d_dut0", i), 32'({busy0, done0, r0, g0, b0, vs0, hs0}),
                  32'({tbl[i].bz0, tbl[i].dn0, tbl[i].rgb0, tbl[i].ovs, 1'b1}));
            check($sformatf("vec%0d_dut2", i), 32'({busy2, done2, r2, g2, b2, vs2, hs2}),
                  32'({tbl[i].bz2, tbl[i].dn2, tbl[i].rgb2, tbl[i].ovs, 1'b1}));
        end

        // Frame-paced switch to src2 with 2 blanking frames; wait for completion with a bound.
        begin
            bit       seen = 1'b0;
            int       bad  = 0;
            logic [2:0] prev_act = act2;
            sel = 3'b100;
            for (int c = 0; c < 200 && !seen; c++) begin
                src_vsync = ((c % 16) < 2) ? 3'b000 : 3'b111;
                @(posedge clk); #1;
                if (prev_act == 3'b100 && act2 == 3'b100 && busy2 && {r2, g2, b2} != 3'b000) bad++;
                if (done2) seen = 1'b1;
                prev_act = act2;
            end
            $display("blank seq: done_seen=%b act=%b bad_rgb_cycles=%0d", seen, act2, bad);
            check("blank_done_seen", 32'(seen), 32'd1);
            check("blank_rgb_black", 32'(bad), 32'd0);
            check("blank_act", 32'(act2), 32'b100);
            @(posedge clk); #1;
            check("blank_resume_rgb", 32'({r2, g2, b2}), 32'b111);
            check("blank_resume_busy", 32'(busy2), 32'd0);
        end

        // Random traffic against the model.
        begin
            logic [2:0] sel_pool [7];
            sel_pool[0] = 3'b001; sel_pool[1] = 3'b010; sel_pool[2] = 3'b100;
            sel_pool[3] = 3'b000; sel_pool[4] = 3'b011; sel_pool[5] = 3'b110;
            sel_pool[6] = 3'b111;
            m0 = '{default: 0};
            m2 = '{default: 0};
            for (int c = 0; c < 3000; c++) begin
                rstn = (c == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
                for (int s = 0; s < 3; s++) src_vsync[s] = ($urandom_range(0, 9) >= 2);
                src_hsync = 3'($urandom);
                src_rgb   = 9'($urandom);
                if ($urandom_range(0, 19) == 0) sel = sel_pool[$urandom_range(0, 6)];
                m0 = model_step(m0, 0, rstn, src_vsync, src_hsync, src_rgb, sel);
                m2 = model_step(m2, 2, rstn, src_vsync, src_hsync, src_rgb, sel);
                @(posedge clk); #1;
                check($sformatf("rand%0d_dut0", c),
                      32'({act0, busy0, done0, vs0, hs0, r0, g0, b0}), 32'(model_out(m0)));
                check($sformatf("rand%0d_dut2", c),
                      32'({act2, busy2, done2, vs2, hs2, r2, g2, b2}), 32'(model_out(m2)));
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
